imm_instr_encoder: RTL and testbench

- Inverse of the core's immediate generator: takes decoded instruction fields plus a 32-bit immediate and packs them into a 32-bit RV32I instruction word.
- Writes each encoded word sequentially into instruction memory through a single write port.
- Used by the boot/debug loader path to fill IMEM before the core is released.
- Accepts one field set per valid/ready handshake, range-checks the immediate per format, and tracks the write pointer, overflow and session completion.

---
 rtl/imm_instr_encoder.sv | 211 +++++++++++++++++++++
 tb/tb_imm_instr_encoder.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : imm_instr_encoder
//  Purpose  : Packs decoded RV32I fields plus a 32-bit immediate back into an
//             instruction word. Each word is written into IMEM through a
//             single write port. This is the inverse of the core's immediate
//             generator, and it is used by the boot/debug loader to fill IMEM.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst        clock, synchronous active-high reset
//    start           opens a session (only honoured from IDLE or DONE)
//    in_valid/ready  field-set handshake (ready only in ACCEPT)
//    in_op_code      instr[6:2]
//    in_rd/rs1/rs2   register fields
//    in_funct3/7     function fields (funct7 for R-type and immediate shifts)
//    in_imm          sign-extended byte-offset immediate
//    in_last         final field set of the session
//    imem_we/addr/wdata  IMEM write port (one-cycle strobe)
//    busy            ACCEPT or WRITE
//    done            session finished
//    err             sticky error, cleared by start or rst
//    count           words written this session
// ============================================================================
module imm_instr_encoder #(
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_op_code,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [4:0] c_op_lui    = 5'b01101;
    localparam logic [4:0] c_op_auipc  = 5'b00101;
    localparam logic [4:0] c_op_opimm  = 5'b00100;
    localparam logic [4:0] c_op_load   = 5'b00000;
    localparam logic [4:0] c_op_jalr   = 5'b11001;
    localparam logic [4:0] c_op_op     = 5'b01100;
    localparam logic [4:0] c_op_store  = 5'b01000;
    localparam logic [4:0] c_op_branch = 5'b11000;
    localparam logic [4:0] c_op_jal    = 5'b11011;

    localparam logic [ADDR_W-1:0] c_base  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   c_depth = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_one   = (ADDR_W+1)'(1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_err;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_last;

    logic [6:0]  w_opc;
    logic        w_imm_i_ok;
    logic        w_imm_b_ok;
    logic        w_imm_j_ok;
    logic        w_is_shift;
    logic [31:0] w_word;
    logic        w_legal;
    logic        w_hs;
    logic        w_full;

    assign w_opc = {in_op_code, 2'b11};

    // "All bits equal" means that the value fits the signed field that the
    // instruction can hold.
    assign w_imm_i_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign w_imm_b_ok = ~in_imm[0] & ((&in_imm[31:12]) | ~(|in_imm[31:12]));
    assign w_imm_j_ok = ~in_imm[0] & ((&in_imm[31:20]) | ~(|in_imm[31:20]));

    // SLLI/SRLI/SRAI (funct3 001/101) carry funct7 in place of imm[11:5].
    assign w_is_shift = (in_op_code == c_op_opimm) && (in_funct3[1:0] == 2'b01);

    always_comb begin
        w_word  = {25'd0, w_opc};
        w_legal = 1'b0;
        case (in_op_code)
            c_op_lui, c_op_auipc: begin
                w_word  = {in_imm[31:12], in_rd, w_opc};
                w_legal = (in_imm[11:0] == 12'd0);
            end
            c_op_opimm: begin
                if (w_is_shift) begin
                    w_word  = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, w_opc};
                    w_legal = (in_imm[31:5] == 27'd0);
                end else begin
                    w_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, w_opc};
                    w_legal = w_imm_i_ok;
                end
            end
            c_op_load, c_op_jalr: begin
                w_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, w_opc};
                w_legal = w_imm_i_ok;
            end
            c_op_op: begin
                w_word  = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, w_opc};
                w_legal = 1'b1;
            end
            c_op_store: begin
                w_word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], w_opc};
                w_legal = w_imm_i_ok;
            end
            c_op_branch: begin
                w_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], w_opc};
                w_legal = w_imm_b_ok;
            end
            c_op_jal: begin
                w_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, w_opc};
                w_legal = w_imm_j_ok;
            end
            default: begin
                w_word  = {25'd0, w_opc};
                w_legal = 1'b0;
            end
        endcase
    end

    assign w_hs   = in_valid && (r_state == ST_ACCEPT);
    assign w_full = (r_count == c_depth);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= c_base;
            r_count <= '0;
            r_err   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_last  <= 1'b0;
        end else begin
            // The write strobe only lives for the single WRITE cycle.
            r_we <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state <= ST_ACCEPT;
                        r_ptr   <= c_base;
                        r_count <= '0;
                        r_err   <= 1'b0;
                    end
                end
                ST_ACCEPT: begin
                    if (w_hs) begin
                        r_addr  <= r_ptr;
                        r_wdata <= w_word;
                        if (w_full) begin
                            // There is no wrap-around. The session ends regardless of in_last.
                            r_err   <= 1'b1;
                            r_state <= ST_DONE;
                        end else if (!w_legal) begin
                            r_err   <= 1'b1;
                            r_state <= in_last ? ST_DONE : ST_ACCEPT;
                        end else begin
                            r_we    <= 1'b1;
                            r_last  <= in_last;
                            r_state <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    r_ptr   <= r_ptr + 1'b1;
                    r_count <= r_count + c_one;
                    r_state <= r_last ? ST_DONE : ST_ACCEPT;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready   = (r_state == ST_ACCEPT);
    assign busy       = (r_state == ST_ACCEPT) || (r_state == ST_WRITE);
    assign done       = (r_state == ST_DONE);
    assign err        = r_err;
    assign count      = r_count;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_imm_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imm_instr_encoder
//  Purpose  : Self-checking bench for imm_instr_encoder. It combines directed
//             sessions with randomized sessions, and compares against a
//             field-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_imm_instr_encoder;

    localparam int P_ADDR_W = 4;
    localparam int P_DEPTH  = 8;
    localparam int P_BASE   = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                in_valid;
    logic                in_ready;
    logic [4:0]          in_op_code;
    logic [4:0]          in_rd;
    logic [4:0]          in_rs1;
    logic [4:0]          in_rs2;
    logic [2:0]          in_funct3;
    logic [6:0]          in_funct7;
    logic [31:0]         in_imm;
    logic                in_last;
    logic                imem_we;
    logic [P_ADDR_W-1:0] imem_addr;
    logic [31:0]         imem_wdata;
    logic                busy;
    logic                done;
    logic                err;
    logic [P_ADDR_W:0]   count;

    imm_instr_encoder #(
        .ADDR_W    (P_ADDR_W),
        .DEPTH     (P_DEPTH),
        .BASE_ADDR (P_BASE)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op_code (in_op_code),
        .in_rd      (in_rd),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_funct3  (in_funct3),
        .in_funct7  (in_funct7),
        .in_imm     (in_imm),
        .in_last    (in_last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .count      (count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int          m_ptr;
    int          m_count;
    logic        m_err;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];

    // ---------------- reference model (field-level arithmetic) --------------
    function automatic logic ref_legal(input logic [4:0] op, input logic [2:0] f3,
                                       input logic [31:0] imm);
        int   s;
        logic ok;
        s  = imm;
        ok = 1'b0;
        case (op)
            5'b01101, 5'b00101: ok = ((imm % 4096) == 0);
            5'b00100: ok = (f3 == 3'd1 || f3 == 3'd5) ? (imm < 32)
                                                      : (s >= -2048 && s <= 2047);
            5'b00000, 5'b11001, 5'b01000: ok = (s >= -2048 && s <= 2047);
            5'b01100: ok = 1'b1;
            5'b11000: ok = ((s % 2) == 0) && s >= -4096 && s <= 4095;
            5'b11011: ok = ((s % 2) == 0) && s >= -1048576 && s <= 1048575;
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] ref_encode(input logic [4:0] op, input logic [4:0] rd,
                                               input logic [4:0] rs1, input logic [4:0] rs2,
                                               input logic [2:0] f3, input logic [6:0] f7,
                                               input logic [31:0] imm);
        logic [31:0] opc, regs_i, regs_s, w;
        opc    = 32'(op) * 4 + 3;
        regs_i = (32'(rs1) << 15) | (32'(f3) << 12) | (32'(rd) << 7) | opc;
        regs_s = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | opc;
        case (op)
            5'b01101, 5'b00101: w = (imm & 32'hFFFF_F000) | (32'(rd) << 7) | opc;
            5'b00100: w = (f3 == 3'd1 || f3 == 3'd5)
                        ? ((32'(f7) << 25) | ((imm % 32) << 20) | regs_i)
                        : (((imm % 4096) << 20) | regs_i);
            5'b00000, 5'b11001: w = ((imm % 4096) << 20) | regs_i;
            5'b01100: w = (32'(f7) << 25) | (32'(rs2) << 20) | regs_i;
            5'b01000: w = (((imm / 32) % 128) << 25) | regs_s | ((imm % 32) << 7);
            5'b11000: w = (((imm / 4096) % 2) << 31) | (((imm / 32) % 64) << 25) | regs_s
                        | (((imm / 2) % 16) << 8) | (((imm / 2048) % 2) << 7);
            5'b11011: w = (((imm / 1048576) % 2) << 31) | (((imm / 2) % 1024) << 21)
                        | (((imm / 2048) % 2) << 20) | (((imm / 4096) % 256) << 12)
                        | (32'(rd) << 7) | opc;
            default:  w = 32'd0;
        endcase
        return w;
    endfunction

    // ---------------- checking helpers ---------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Every IMEM write must match the next expected write, in order.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            n_cmp++;
            if (exp_data_q.size() == 0) begin
                n_bad++;
                $error("FAIL unexpected_write: observed addr %0d data 0x%08h expected no write",
                       imem_addr, imem_wdata);
            end else begin
                logic [31:0] ea, ed;
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                assert ({32'(imem_addr), imem_wdata} === {ea, ed}) else begin
                    n_bad++;
                    $error("FAIL imem_write: observed addr %0d data 0x%08h expected addr %0d data 0x%08h",
                           imem_addr, imem_wdata, ea, ed);
                end
            end
        end
    end

    // ---------------- stimulus helpers ---------------------------------------
    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_ptr   = P_BASE;
        m_count = 0;
        m_err   = 1'b0;
    endtask

    task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input logic last);
        int guard;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("ready_wait", {31'd0, in_ready}, 32'd1);
        if (in_ready === 1'b1) begin
            in_op_code = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
            in_funct3 = f3; in_funct7 = f7; in_imm = imm; in_last = last;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (m_count == P_DEPTH) begin
                m_err = 1'b1;
            end else if (!ref_legal(op, f3, imm)) begin
                m_err = 1'b1;
            end else begin
                exp_addr_q.push_back(32'(m_ptr));
                exp_data_q.push_back(ref_encode(op, rd, rs1, rs2, f3, f7, imm));
                m_ptr++;
                m_count++;
            end
        end
    endtask

    task automatic finish_session(input string tag);
        int guard;
        guard = 0;
        while (done !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
        check({tag, "_count"}, 32'(count), 32'(m_count));
        check({tag, "_err"}, {31'd0, err}, {31'd0, m_err});
        check({tag, "_drained"}, 32'(exp_data_q.size()), 32'd0);
    endtask

    task automatic rand_item(input logic want_legal, output logic [4:0] op, output logic [4:0] rd,
                             output logic [4:0] rs1, output logic [4:0] rs2,
                             output logic [2:0] f3, output logic [6:0] f7,
                             output logic [31:0] imm);
        logic [4:0] ops [10];
        int         bnd [11];
        logic [31:0] r;
        ops = '{5'b01101, 5'b00101, 5'b00100, 5'b00000, 5'b11001,
                5'b01100, 5'b01000, 5'b11000, 5'b11011, 5'b11111};
        bnd = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098, 1048574, -1048576, 1048576};
        for (int t = 0; t < 200; t++) begin
            op  = ops[$urandom_range(0, 9)];
            rd  = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
            f3  = 3'($urandom); f7  = 7'($urandom);
            r   = $urandom;
            case ($urandom_range(0, 5))
                0:       imm = 32'($urandom_range(0, 80)) - 32'd40;
                1:       imm = r;
                2:       imm = r & 32'hFFFF_F000;
                3:       imm = 32'($urandom_range(0, 40));
                4:       imm = 32'(bnd[$urandom_range(0, 10)]);
                default: imm = (32'($urandom_range(0, 200)) - 32'd100) * 2;
            endcase
            if (!want_legal || ref_legal(op, f3, imm)) break;
        end
    endtask

    // ---------------- directed + random sequence -----------------------------
    initial begin
        logic [4:0]  op, rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        int          n;

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_op_code = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0;
        m_ptr = P_BASE; m_count = 0; m_err = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_done",  {31'd0, done}, 32'd0);
        check("rst_err",   {31'd0, err}, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_we",    {31'd0, imem_we}, 32'd0);
        check("rst_addr",  32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);

        // in_valid while IDLE is ignored
        in_valid = 1'b1; in_op_code = 5'b01100;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        check("idle_valid_ready", {31'd0, in_ready}, 32'd0);

        // Session A: addi x1,x0,-1 ; lui x5 ; sw x2,8(x1) with last
        do_start();
        check("start_ready", {31'd0, in_ready}, 32'd1);
        check("start_busy",  {31'd0, busy}, 32'd1);
        send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b0);
        check("addi_we",    {31'd0, imem_we}, 32'd1);
        check("addi_wdata", imem_wdata, 32'hFFF0_0093);
        check("addi_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("addi_count", 32'(count), 32'd1);
        start = 1'b1;                      // ignored while ACCEPT
        @(negedge clk);
        start = 1'b0;
        send(5'b01101, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 1'b0);
        check("lui_wdata", imem_wdata, 32'h1234_52B7);
        send(5'b01000, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b1);
        check("sw_wdata", imem_wdata, 32'h0020_A423);
        finish_session("sessA");

        // Session B: beq -4 ; jal x1,8
        do_start();
        send(5'b11000, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 1'b0);
        check("beq_wdata", imem_wdata, 32'hFE00_0EE3);
        send(5'b11011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b1);
        check("jal_wdata", imem_wdata, 32'h0080_00EF);
        finish_session("sessB");

        // Session C: out-of-range addi, beq 6, unsupported op with last
        do_start();
        send(5'b00100, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0);
        check("range_err", {31'd0, err}, 32'd1);
        check("range_we",  {31'd0, imem_we}, 32'd0);
        send(5'b11000, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd6, 1'b0);
        check("beq6_wdata", imem_wdata, 32'h0000_0363);
        send(5'b11111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 1'b1);
        finish_session("sessC");

        // Full: DEPTH legal words, then one more legal word to overflow
        do_start();
        for (int i = 0; i <= P_DEPTH; i++) begin
            rand_item(1'b1, op, rd, rs1, rs2, f3, f7, imm);
            send(op, rd, rs1, rs2, f3, f7, imm, 1'b0);
        end
        finish_session("full");
        do_start();
        check("restart_err",   {31'd0, err}, 32'd0);
        check("restart_count", 32'(count), 32'd0);
        rand_item(1'b1, op, rd, rs1, rs2, f3, f7, imm);
        send(op, rd, rs1, rs2, f3, f7, imm, 1'b1);
        finish_session("restart");

        // Randomized sessions mixing legal and illegal field sets
        for (int s = 0; s < 8; s++) begin
            do_start();
            n = $urandom_range(1, 7);
            for (int i = 0; i < n; i++) begin
                rand_item(($urandom_range(0, 3) != 0), op, rd, rs1, rs2, f3, f7, imm);
                send(op, rd, rs1, rs2, f3, f7, imm, (i == n - 1));
            end
            finish_session("rand");
        end

        // rst during a WRITE cycle cuts the write
        do_start();
        for (int i = 0; i < 3; i++) begin
            rand_item(1'b1, op, rd, rs1, rs2, f3, f7, imm);
            send(op, rd, rs1, rs2, f3, f7, imm, 1'b0);
        end
        check("pre_rst_we", {31'd0, imem_we}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_ptr = P_BASE; m_count = 0; m_err = 1'b0;
        check("rst_write_we",    {31'd0, imem_we}, 32'd0);
        check("rst_write_count", 32'(count), 32'd0);
        check("rst_write_ready", {31'd0, in_ready}, 32'd0);
        check("rst_write_busy",  {31'd0, busy}, 32'd0);
        in_valid = 1'b1; in_op_code = 5'b01100;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        check("rst_idle_ready", {31'd0, in_ready}, 32'd0);
        do_start();
        send(5'b01100, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'd0, 1'b1);
        finish_session("resume");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
